// File: rtl/mestre_busca_caminho.sv
// Host-side master for the path-search accelerator.
// Forwards obstacle writes, launches searches and replays the path source-first.
module mestre_busca_caminho #(
  parameter int ADDR_WIDTH    = 10,
  parameter int MAX_CAMINHO   = 64,
  parameter int TIMEOUT_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_in,
  output logic                  cmd_ready_out,
  input  logic [ADDR_WIDTH-1:0] cmd_fonte_in,
  input  logic [ADDR_WIDTH-1:0] cmd_destino_in,
  input  logic                  obs_valid_in,
  output logic                  obs_ready_out,
  input  logic [ADDR_WIDTH-1:0] obs_addr_in,
  input  logic                  obs_data_in,
  output logic [ADDR_WIDTH-1:0] top_addr_fonte_out,
  output logic [ADDR_WIDTH-1:0] top_addr_destino_out,
  output logic                  top_wr_fonte_out,
  output logic                  obstaculos_wr_enable_out,
  output logic [ADDR_WIDTH-1:0] obstaculos_wr_addr_out,
  output logic                  obstaculos_wr_data_out,
  input  logic [ADDR_WIDTH-1:0] gma_read_data_in,
  input  logic                  gma_pronto_in,
  output logic                  res_valid_out,
  input  logic                  res_ready_in,
  output logic [ADDR_WIDTH-1:0] res_addr_out,
  output logic                  res_last_out,
  output logic [ADDR_WIDTH-1:0] comprimento_out,
  output logic                  ocupado_out,
  output logic                  concluido_out,
  output logic                  erro_timeout_out,
  output logic                  erro_overflow_out
);

  localparam int PW = (MAX_CAMINHO > 1) ? $clog2(MAX_CAMINHO) : 1;
  localparam logic [ADDR_WIDTH-1:0] MAXC = ADDR_WIDTH'(MAX_CAMINHO);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_MAX = '1;

  typedef enum logic [2:0] {
    OCIOSO, DISPARO, AGUARDA, COLETA, ENTREGA
  } estado_t;

  estado_t estado_q, estado_d;

  logic [ADDR_WIDTH-1:0]    fonte_q, fonte_d;
  logic [ADDR_WIDTH-1:0]    destino_q, destino_d;
  logic [ADDR_WIDTH-1:0]    count_q, count_d;
  logic [ADDR_WIDTH-1:0]    comp_q, comp_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d, wd_inc;
  logic                     to_q, to_d;
  logic                     ov_q, ov_d;
  logic                     conc_q, conc_d;
  logic                     obs_we_q;
  logic [ADDR_WIDTH-1:0]    obs_addr_q;
  logic                     obs_data_q;

  logic [ADDR_WIDTH-1:0] buf_q [MAX_CAMINHO];
  logic                  buf_we;
  logic [PW-1:0]         buf_idx;
  logic                  fim;
  logic                  cmd_acc;
  logic                  obs_acc;

  assign obs_ready_out = (estado_q == OCIOSO);
  assign cmd_ready_out = (estado_q == OCIOSO) && !obs_valid_in;
  assign cmd_acc       = cmd_valid_in && cmd_ready_out;
  assign obs_acc       = obs_valid_in && obs_ready_out;
  assign wd_inc        = wd_q + 1'b1;

  always_comb begin
    estado_d  = estado_q;
    fonte_d   = fonte_q;
    destino_d = destino_q;
    count_d   = count_q;
    comp_d    = comp_q;
    ptr_d     = ptr_q;
    wd_d      = wd_q;
    to_d      = to_q;
    ov_d      = ov_q;
    conc_d    = 1'b0;
    buf_we    = 1'b0;
    buf_idx   = PW'(count_q);
    fim       = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (cmd_acc) begin
          fonte_d   = cmd_fonte_in;
          destino_d = cmd_destino_in;
          to_d      = 1'b0;
          ov_d      = 1'b0;
          comp_d    = '0;
          count_d   = '0;
          estado_d  = DISPARO;
        end
      end
      DISPARO: begin
        wd_d     = '0;
        estado_d = AGUARDA;
      end
      AGUARDA: begin
        wd_d = (wd_q == WD_MAX) ? wd_q : wd_inc;
        if (gma_pronto_in) begin
          buf_we  = 1'b1;
          buf_idx = '0;
          count_d = ADDR_WIDTH'(1);
          if (gma_read_data_in == fonte_q) begin
            comp_d   = ADDR_WIDTH'(1);
            ptr_d    = '0;
            estado_d = ENTREGA;
          end else begin
            estado_d = COLETA;
          end
        end else if (wd_inc == WD_MAX) begin
          to_d     = 1'b1;
          conc_d   = 1'b1;
          estado_d = OCIOSO;
        end
      end
      COLETA: begin
        if (gma_pronto_in) begin
          if (count_q < MAXC) begin
            buf_we  = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            ov_d = 1'b1;
          end
          fim = (gma_read_data_in == fonte_q);
        end else begin
          fim = 1'b1;
        end
        // An overflowed path is incomplete, so it is never replayed
        if (fim) begin
          comp_d = count_d;
          if (ov_d) begin
            conc_d   = 1'b1;
            estado_d = OCIOSO;
          end else begin
            ptr_d    = PW'(count_d - 1'b1);
            estado_d = ENTREGA;
          end
        end
      end
      ENTREGA: begin
        if (res_ready_in) begin
          if (ptr_q == '0) begin
            conc_d   = 1'b1;
            estado_d = OCIOSO;
          end else begin
            ptr_d = ptr_q - 1'b1;
          end
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= OCIOSO;
      fonte_q    <= '0;
      destino_q  <= '0;
      count_q    <= '0;
      comp_q     <= '0;
      ptr_q      <= '0;
      wd_q       <= '0;
      to_q       <= 1'b0;
      ov_q       <= 1'b0;
      conc_q     <= 1'b0;
      obs_we_q   <= 1'b0;
      obs_addr_q <= '0;
      obs_data_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      fonte_q   <= fonte_d;
      destino_q <= destino_d;
      count_q   <= count_d;
      comp_q    <= comp_d;
      ptr_q     <= ptr_d;
      wd_q      <= wd_d;
      to_q      <= to_d;
      ov_q      <= ov_d;
      conc_q    <= conc_d;
      obs_we_q  <= obs_acc;
      if (obs_acc) begin
        obs_addr_q <= obs_addr_in;
        obs_data_q <= obs_data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[buf_idx] <= gma_read_data_in;
    end
  end

  assign top_addr_fonte_out       = fonte_q;
  assign top_addr_destino_out     = destino_q;
  assign top_wr_fonte_out         = (estado_q == DISPARO);
  assign obstaculos_wr_enable_out = obs_we_q;
  assign obstaculos_wr_addr_out   = obs_addr_q;
  assign obstaculos_wr_data_out   = obs_data_q;
  assign res_valid_out            = (estado_q == ENTREGA);
  assign res_addr_out             = res_valid_out ? buf_q[ptr_q] : '0;
  assign res_last_out             = res_valid_out && (ptr_q == '0);
  assign comprimento_out          = comp_q;
  assign ocupado_out              = (estado_q != OCIOSO);
  assign concluido_out            = conc_q;
  assign erro_timeout_out         = to_q;
  assign erro_overflow_out        = ov_q;

endmodule

// File: tb/tb_mestre_busca_caminho.sv
// Directed bench for mestre_busca_caminho: cycle table plus
// hand-written obstacle, timeout, overflow and reset sequences.
module tb_mestre_busca_caminho;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid_in;
  logic       cmd_ready_out;
  logic [9:0] cmd_fonte_in;
  logic [9:0] cmd_destino_in;
  logic       obs_valid_in;
  logic       obs_ready_out;
  logic [9:0] obs_addr_in;
  logic       obs_data_in;
  logic [9:0] top_addr_fonte_out;
  logic [9:0] top_addr_destino_out;
  logic       top_wr_fonte_out;
  logic       obstaculos_wr_enable_out;
  logic [9:0] obstaculos_wr_addr_out;
  logic       obstaculos_wr_data_out;
  logic [9:0] gma_read_data_in;
  logic       gma_pronto_in;
  logic       res_valid_out;
  logic       res_ready_in;
  logic [9:0] res_addr_out;
  logic       res_last_out;
  logic [9:0] comprimento_out;
  logic       ocupado_out;
  logic       concluido_out;
  logic       erro_timeout_out;
  logic       erro_overflow_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mestre_busca_caminho #(
    .ADDR_WIDTH(10), .MAX_CAMINHO(4), .TIMEOUT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_fonte_in(cmd_fonte_in), .cmd_destino_in(cmd_destino_in),
    .obs_valid_in(obs_valid_in), .obs_ready_out(obs_ready_out),
    .obs_addr_in(obs_addr_in), .obs_data_in(obs_data_in),
    .top_addr_fonte_out(top_addr_fonte_out),
    .top_addr_destino_out(top_addr_destino_out),
    .top_wr_fonte_out(top_wr_fonte_out),
    .obstaculos_wr_enable_out(obstaculos_wr_enable_out),
    .obstaculos_wr_addr_out(obstaculos_wr_addr_out),
    .obstaculos_wr_data_out(obstaculos_wr_data_out),
    .gma_read_data_in(gma_read_data_in), .gma_pronto_in(gma_pronto_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_addr_out(res_addr_out), .res_last_out(res_last_out),
    .comprimento_out(comprimento_out), .ocupado_out(ocupado_out),
    .concluido_out(concluido_out),
    .erro_timeout_out(erro_timeout_out),
    .erro_overflow_out(erro_overflow_out)
  );

  typedef struct {
    logic       cv;
    logic [9:0] f;
    logic [9:0] d;
    logic       pr;
    logic [9:0] dat;
    logic       rr;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic cv, input logic [9:0] f, input logic [9:0] d,
    input logic pr, input logic [9:0] dat, input logic rr,
    input logic crdy, input logic twr, input logic rv,
    input logic [9:0] ra, input logic rl, input logic conc,
    input logic oc, input logic [9:0] comp);
    vec_t r;
    r.cv = cv; r.f = f; r.d = d;
    r.pr = pr; r.dat = dat; r.rr = rr;
    r.exp = {crdy, twr, rv, ra, rl, conc, oc, comp};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    cmd_valid_in = 0; cmd_fonte_in = 0; cmd_destino_in = 0;
    obs_valid_in = 0; obs_addr_in = 0; obs_data_in = 0;
    gma_pronto_in = 0; gma_read_data_in = 0; res_ready_in = 0;
  endtask

  function automatic logic [63:0] zeros_vec();
    return {top_addr_fonte_out, top_addr_destino_out,
            top_wr_fonte_out, obstaculos_wr_enable_out,
            obstaculos_wr_addr_out, obstaculos_wr_data_out,
            res_valid_out, res_addr_out, res_last_out,
            comprimento_out, ocupado_out, concluido_out,
            erro_timeout_out, erro_overflow_out};
  endfunction

  logic [9:0] nodes [6];
  int seen;
  int n;
  bit done;

  initial begin
    idle_in();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_ready", {obs_ready_out, cmd_ready_out}, 2'b11);
    chk("reset_zero", zeros_vec(), 0);

    // Obstacle writes on consecutive cycles
    nxt(); obs_valid_in = 1; obs_addr_in = 5; obs_data_in = 1;
    @(negedge clk);
    chk("obs_rdy", {obs_ready_out, cmd_ready_out}, 2'b10);
    nxt(); obs_addr_in = 6; obs_data_in = 1;
    @(negedge clk);
    chk("obs_wr0", {obstaculos_wr_enable_out, obstaculos_wr_addr_out,
                    obstaculos_wr_data_out}, {1'b1, 10'd5, 1'b1});
    nxt(); obs_addr_in = 7; obs_data_in = 0;
    @(negedge clk);
    chk("obs_wr1", {obstaculos_wr_enable_out, obstaculos_wr_addr_out,
                    obstaculos_wr_data_out}, {1'b1, 10'd6, 1'b1});
    nxt(); obs_valid_in = 0;
    @(negedge clk);
    chk("obs_wr2", {obstaculos_wr_enable_out, obstaculos_wr_addr_out,
                    obstaculos_wr_data_out}, {1'b1, 10'd7, 1'b0});
    nxt();
    @(negedge clk);
    chk("obs_wr_end", obstaculos_wr_enable_out, 1'b0);

    // Cycle table: plain search, back-pressured search, fonte==destino
    tbl.push_back(v(1,3,9,0,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,1,9,0, 0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,1,8,0, 0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,1,4,0, 0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,1,3,0, 0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,1, 0,0,1,3,0,0,1,4));
    tbl.push_back(v(0,0,0,0,0,1, 0,0,1,4,0,0,1,4));
    tbl.push_back(v(0,0,0,0,0,1, 0,0,1,8,0,0,1,4));
    tbl.push_back(v(0,0,0,0,0,1, 0,0,1,9,1,0,1,4));
    tbl.push_back(v(0,0,0,0,0,0, 1,0,0,0,0,1,0,4));
    tbl.push_back(v(1,3,9,0,0,0, 1,0,0,0,0,0,0,4));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,1,9,0, 0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,1,8,0, 0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,1,4,0, 0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,1,3,0, 0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,1, 0,0,1,3,0,0,1,4));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,1,4,0,0,1,4));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,1,4,0,0,1,4));
    tbl.push_back(v(0,0,0,0,0,1, 0,0,1,4,0,0,1,4));
    tbl.push_back(v(0,0,0,0,0,1, 0,0,1,8,0,0,1,4));
    tbl.push_back(v(0,0,0,0,0,1, 0,0,1,9,1,0,1,4));
    tbl.push_back(v(0,0,0,0,0,0, 1,0,0,0,0,1,0,4));
    tbl.push_back(v(1,7,7,0,0,0, 1,0,0,0,0,0,0,4));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,1,7,0, 0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,1, 0,0,1,7,1,0,1,1));
    tbl.push_back(v(0,0,0,0,0,0, 1,0,0,0,0,1,0,1));

    foreach (tbl[i]) begin
      nxt();
      cmd_valid_in = tbl[i].cv;
      cmd_fonte_in = tbl[i].f;
      cmd_destino_in = tbl[i].d;
      gma_pronto_in = tbl[i].pr;
      gma_read_data_in = tbl[i].dat;
      res_ready_in = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("row%0d", i),
          {cmd_ready_out, top_wr_fonte_out, res_valid_out,
           res_addr_out, res_last_out, concluido_out,
           ocupado_out, comprimento_out}, tbl[i].exp);
    end
    chk("top_addr", {top_addr_fonte_out, top_addr_destino_out},
        {10'd7, 10'd7});

    // Timeout: no pronto ever arrives
    nxt(); idle_in(); cmd_valid_in = 1; cmd_fonte_in = 1;
    cmd_destino_in = 2;
    @(negedge clk);
    chk("to_accept", cmd_ready_out, 1'b1);
    seen = 0; n = 0; done = 0;
    for (int i = 1; i <= 40 && !done; i++) begin
      nxt(); cmd_valid_in = 0;
      @(negedge clk);
      if (res_valid_out) seen++;
      if (concluido_out) begin
        n = i; done = 1;
      end
    end
    chk("to_latency", n, 17);
    chk("to_flags", {erro_timeout_out, erro_overflow_out, ocupado_out},
        3'b100);
    chk("to_no_beats", seen, 0);

    // Overflow: six nodes ending in fonte, buffer holds four
    nodes[0] = 2; nodes[1] = 10; nodes[2] = 11;
    nodes[3] = 12; nodes[4] = 13; nodes[5] = 1;
    nxt(); cmd_valid_in = 1; cmd_fonte_in = 1; cmd_destino_in = 2;
    @(negedge clk);
    chk("ov_accept", cmd_ready_out, 1'b1);
    nxt(); cmd_valid_in = 0;
    @(negedge clk);
    chk("to_cleared", {erro_timeout_out, top_wr_fonte_out}, 2'b01);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      nxt(); gma_pronto_in = 1; gma_read_data_in = nodes[i];
      @(negedge clk);
      if (res_valid_out) seen++;
    end
    nxt(); gma_pronto_in = 0; gma_read_data_in = 0;
    @(negedge clk);
    chk("ov_end", {concluido_out, erro_overflow_out, ocupado_out,
                   comprimento_out}, {1'b1, 1'b1, 1'b0, 10'd4});
    for (int i = 0; i < 3; i++) begin
      nxt();
      @(negedge clk);
      if (res_valid_out) seen++;
    end
    chk("ov_no_beats", seen, 0);

    // Obstacle beats a simultaneous command, then reset mid-COLETA
    nxt(); obs_valid_in = 1; obs_addr_in = 20; obs_data_in = 1;
    cmd_valid_in = 1; cmd_fonte_in = 3; cmd_destino_in = 9;
    @(negedge clk);
    chk("simul_rdy", {obs_ready_out, cmd_ready_out}, 2'b10);
    nxt(); obs_valid_in = 0;
    @(negedge clk);
    chk("simul_next", {cmd_ready_out, obstaculos_wr_enable_out,
                       obstaculos_wr_addr_out, obstaculos_wr_data_out},
        {1'b1, 1'b1, 10'd20, 1'b1});
    nxt(); cmd_valid_in = 0;
    @(negedge clk);
    chk("simul_start", {top_wr_fonte_out, ocupado_out}, 2'b11);
    nxt(); gma_pronto_in = 1; gma_read_data_in = 9;
    @(negedge clk);
    nxt(); gma_read_data_in = 8;
    @(negedge clk);
    chk("coleta_busy", {ocupado_out, res_valid_out}, 2'b10);
    nxt(); rst = 1; gma_read_data_in = 4;
    @(negedge clk);
    nxt(); rst = 0; gma_read_data_in = 3;
    @(negedge clk);
    chk("rst_ready", {obs_ready_out, cmd_ready_out}, 2'b11);
    chk("rst_zero", zeros_vec(), 0);
    seen = 0;
    nxt(); gma_pronto_in = 0; gma_read_data_in = 0; res_ready_in = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res_valid_out || concluido_out || ocupado_out) seen++;
      nxt();
    end
    chk("rst_quiet", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mestre_busca_caminho.md
Name: mestre_busca_caminho

Overview:
- Host-side master for the path-search accelerator: the other end of its command, obstacle-load and result-read interface.
- Forwards obstacle-map writes and issues source/destination search commands.
- Collects the path nodes the accelerator emits on its result port (destination to source) into a local buffer.
- Streams the path back to the host in source-to-destination order over a valid/ready interface.

Parameters:
ADDR_WIDTH, 10, node address width; matches accelerator ADDR_WIDTH
MAX_CAMINHO, 64, path buffer depth in nodes (power of two)
TIMEOUT_WIDTH, 20, width of wait-for-result watchdog counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid_in  in  1  host search request
cmd_ready_out  out  1  request accepted when both valid and ready are high
cmd_fonte_in  in  ADDR_WIDTH  source node
cmd_destino_in  in  ADDR_WIDTH  destination node
obs_valid_in  in  1  host obstacle write
obs_ready_out  out  1  obstacle write accepted
obs_addr_in  in  ADDR_WIDTH  obstacle node address
obs_data_in  in  1  1 = blocked
top_addr_fonte_out  out  ADDR_WIDTH  to accelerator source input
top_addr_destino_out  out  ADDR_WIDTH  to accelerator destination input
top_wr_fonte_out  out  1  one-cycle search start strobe
obstaculos_wr_enable_out  out  1  to accelerator obstacle write enable
obstaculos_wr_addr_out  out  ADDR_WIDTH  obstacle write address
obstaculos_wr_data_out  out  1  obstacle write data
gma_read_data_in  in  ADDR_WIDTH  path node from accelerator
gma_pronto_in  in  1  path node valid, one node per cycle while high
res_valid_out  out  1  result node valid
res_ready_in  in  1  host accepts result node
res_addr_out  out  ADDR_WIDTH  result node, source first
res_last_out  out  1  marks destination node (final beat)
comprimento_out  out  ADDR_WIDTH  number of nodes captured in last search
ocupado_out  out  1  state not OCIOSO
concluido_out  out  1  one-cycle pulse at end of search, success or error
erro_timeout_out  out  1  sticky; cleared on next accepted command
erro_overflow_out  out  1  sticky; cleared on next accepted command

Behaviour:
Reset:
- All outputs are 0 on reset, except obs_ready_out = 1 and cmd_ready_out = 1.
- State = OCIOSO; counters and flags cleared.
- Reset in any state aborts the operation; no further strobes or result beats are issued.

States: OCIOSO, DISPARO, AGUARDA, COLETA, ENTREGA.

OCIOSO:
- obs_ready_out = 1.
- cmd_ready_out = !obs_valid_in, so an obstacle write wins over a simultaneous command.
- Obstacle accept: registered one cycle later as obstaculos_wr_enable_out = 1 for exactly one cycle, with addr and data; back-to-back writes run one per cycle.
- Command accept: latch fonte/destino onto top_addr_*_out, which hold until the next accept. Clear the error flags and comprimento. Go to DISPARO.

DISPARO:
- top_wr_fonte_out = 1 for exactly one cycle, then AGUARDA.
- Watchdog cleared.

AGUARDA:
- Watchdog increments each cycle.
- gma_pronto_in = 1: capture gma_read_data_in into buffer[0], count = 1, go to COLETA. If that node equals fonte, go straight to ENTREGA instead (covers fonte == destino).
- Watchdog reaches all-ones: set erro_timeout_out, pulse concluido_out, go to OCIOSO. No result beats.

COLETA:
- Each cycle with gma_pronto_in = 1 and count < MAX_CAMINHO: buffer[count] = data, count++.
- Captured node equals latched fonte: capture it, then go to ENTREGA.
- gma_pronto_in falls before fonte is seen: go to ENTREGA with the nodes captured so far.
- gma_pronto_in = 1 with count == MAX_CAMINHO: set erro_overflow_out and drop further nodes. Stay in COLETA until fonte arrives or pronto falls, then go to OCIOSO with concluido_out pulsed and no result beats.
- comprimento_out = count, updated on exit.

ENTREGA:
- Read pointer starts at count-1 and decrements, giving source-first order.
- res_valid_out = 1; res_addr_out = buffer[ptr]; res_last_out = (ptr == 0).
- Pointer decrements only on res_valid_out & res_ready_in.
- res_addr_out and res_last_out stay stable while valid && !ready.
- Handshake on the last beat: concluido_out pulses next cycle, go to OCIOSO.
- obs_ready_out = 0 and cmd_ready_out = 0 in every state except OCIOSO.

Widths:
- count is ADDR_WIDTH wide.
- The watchdog saturates and does not wrap.

Test Plan:
- Obstacles only: obs writes (5,1),(6,1),(7,0) on consecutive cycles -> obstaculos_wr_enable_out high for 3 consecutive cycles, one cycle after each accept, with matching addr/data.
- Search fonte=3, destino=9; accelerator pulses pronto for 4 cycles with 9,8,4,3 -> top_wr_fonte_out pulses once; beats 3,4,8,9; res_last on 9; comprimento_out = 4; concluido_out pulses once.
- Back-pressure: same path, res_ready_in toggled 1,0,0,1 -> no beat lost or duplicated; res_addr_out stable during stalls.
- Timeout with TIMEOUT_WIDTH=4, no pronto -> erro_timeout_out = 1 after 15 wait cycles, no res_valid_out; next cmd accept clears the flag.
- Overflow with MAX_CAMINHO=4, six nodes ending in fonte -> erro_overflow_out = 1, no result beats, return to OCIOSO.
- Simultaneous obs_valid_in and cmd_valid_in in OCIOSO -> obstacle accepted first, command next cycle. rst asserted mid-COLETA -> all outputs reset values next cycle, no result beats.
